pc_fetch_sequencer: RTL and testbench

//  Consumer end of the branch-resolution interface: owns the program counter and

---
 rtl/pc_fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Owns the program counter. Fetches one instruction at a time
//               from instruction memory over a valid/ready request and a
//               valid-qualified response, presents it to the single-cycle
//               datapath for exactly one execute step, then selects the next
//               PC from the branch unit (NextPCSrc/BrTarget) or PC+4.
//               A taken redirect whose target is not word aligned parks the
//               sequencer in a sticky trap state until reset.
// Ports       : clk, rst_n (synchronous, active-low)
//               NextPCSrc, BrTarget   - branch unit redirect request
//               stall_i               - hold the executing instruction
//               imem_req_*            - fetch request (valid/ready/addr)
//               imem_rsp_*            - fetch response (valid/data)
//               pc_o, pc_plus4_o      - current PC and its link value
//               inst_o, inst_valid_o  - instruction presented to the datapath
//               trap_o                - sticky misaligned-target trap
// Options     : FETCH_BRANCH_STATS_EN adds instret_o / taken_o counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] BrTarget,
  input  logic            stall_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [31:0]     inst_o,
  output logic            inst_valid_o,
  output logic            trap_o
`ifdef FETCH_BRANCH_STATS_EN
  ,
  output logic [XLEN-1:0] instret_o,
  output logic [XLEN-1:0] taken_o
`endif
);

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_TRAP = 3'd4;

  localparam logic [XLEN-1:0] c_four    = XLEN'(4);
  localparam logic [XLEN-1:0] c_bit0_lo = ~XLEN'(1);

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            r_trap;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_tgt;
  logic            w_misaligned;
  logic            w_exec_exit;

  // Addition wraps naturally at 2^XLEN, so the top word rolls over to 0.
  assign w_pc_plus4   = r_pc + c_four;
  // JALR semantics: bit 0 of the target is always discarded; bit 1 set on a
  // taken redirect means the target is not word aligned.
  assign w_tgt        = BrTarget & c_bit0_lo;
  assign w_misaligned = NextPCSrc & w_tgt[1];
  // The one cycle in which an executing instruction retires and the PC moves.
  assign w_exec_exit  = (r_state == S_EXEC) & ~stall_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_trap  <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_REQ;
        S_REQ: begin
          // Address is r_pc, which cannot change here, so it is stable
          // until the request is accepted.
          if (imem_req_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid_i) begin
            r_inst  <= imem_rsp_data_i;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall_i) begin
            if (w_misaligned) begin
              // PC stays on the faulting instruction for post-mortem.
              r_trap  <= 1'b1;
              r_state <= S_TRAP;
            end else begin
              r_pc    <= NextPCSrc ? w_tgt : w_pc_plus4;
              r_inst  <= NOP_INST;
              r_state <= S_REQ;
            end
          end
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign imem_req_valid_o = (r_state == S_REQ);
  assign imem_addr_o      = r_pc;
  assign pc_o             = r_pc;
  assign pc_plus4_o       = w_pc_plus4;
  assign inst_o           = r_inst;
  assign inst_valid_o     = (r_state == S_EXEC);
  assign trap_o           = r_trap;

`ifdef FETCH_BRANCH_STATS_EN
  logic [XLEN-1:0] r_instret;
  logic [XLEN-1:0] r_taken;

  // A trapping redirect never retires, so it is excluded from both counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instret <= '0;
      r_taken   <= '0;
    end else if (w_exec_exit && !w_misaligned) begin
      r_instret <= r_instret + XLEN'(1);
      if (NextPCSrc) r_taken <= r_taken + XLEN'(1);
    end
  end

  assign instret_o = r_instret;
  assign taken_o   = r_taken;
`else
  // Retirement pulse only feeds the optional counters.
  logic w_unused;
  assign w_unused = w_exec_exit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Directed self-checking bench for pc_fetch_sequencer. A small
//               instruction memory model answers one cycle after acceptance
//               with data = 0xA500_0000 ^ address. A second instance with
//               RESET_PC = 0xFFFF_FFFC exercises PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_npc = 1'b0;
  logic [31:0] r_brt = '0;
  logic        r_stall = 1'b0;
  logic        r_ready = 1'b1;
  logic        r_rsp_en = 1'b1;

  logic        w_req_valid, w_inst_valid, w_trap, w_rsp_valid;
  logic [31:0] w_addr, w_pc, w_plus4, w_inst, w_rsp_data;
  logic        r_pend = 1'b0;
  logic [31:0] r_pend_addr = '0;

  // Wrap instance: always ready, never redirects or stalls.
  logic        r_npc2 = 1'b0;
  logic [31:0] r_brt2 = '0;
  logic        r_stall2 = 1'b0;
  logic        r_ready2 = 1'b1;
  logic        w_req2, w_valid2, w_trap2, w_rsp_valid2;
  logic [31:0] w_addr2, w_pc2, w_plus4_2, w_inst2, w_rsp_data2;
  logic        r_pend2 = 1'b0;
  logic [31:0] r_pend_addr2 = '0;

`ifdef FETCH_BRANCH_STATS_EN
  logic [31:0] w_instret, w_taken, w_instret2, w_taken2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Memory model: one outstanding request, response held until consumed.
  always @(posedge clk) begin
    if (!rst_n) r_pend <= 1'b0;
    else if (w_req_valid && r_ready) begin
      r_pend      <= 1'b1;
      r_pend_addr <= w_addr;
    end else if (w_rsp_valid) r_pend <= 1'b0;
  end
  assign w_rsp_valid = r_pend & r_rsp_en;
  assign w_rsp_data  = inst_at(r_pend_addr);

  always @(posedge clk) begin
    if (!rst_n) r_pend2 <= 1'b0;
    else if (w_req2 && r_ready2) begin
      r_pend2      <= 1'b1;
      r_pend_addr2 <= w_addr2;
    end else if (w_rsp_valid2) r_pend2 <= 1'b0;
  end
  assign w_rsp_valid2 = r_pend2;
  assign w_rsp_data2  = inst_at(r_pend_addr2);

  pc_fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(r_npc), .BrTarget(r_brt),
    .stall_i(r_stall), .imem_req_valid_o(w_req_valid),
    .imem_req_ready_i(r_ready), .imem_addr_o(w_addr),
    .imem_rsp_valid_i(w_rsp_valid), .imem_rsp_data_i(w_rsp_data),
    .pc_o(w_pc), .pc_plus4_o(w_plus4), .inst_o(w_inst),
    .inst_valid_o(w_inst_valid), .trap_o(w_trap)
`ifdef FETCH_BRANCH_STATS_EN
    , .instret_o(w_instret), .taken_o(w_taken)
`endif
  );

  pc_fetch_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(r_npc2), .BrTarget(r_brt2),
    .stall_i(r_stall2), .imem_req_valid_o(w_req2),
    .imem_req_ready_i(r_ready2), .imem_addr_o(w_addr2),
    .imem_rsp_valid_i(w_rsp_valid2), .imem_rsp_data_i(w_rsp_data2),
    .pc_o(w_pc2), .pc_plus4_o(w_plus4_2), .inst_o(w_inst2),
    .inst_valid_o(w_valid2), .trap_o(w_trap2)
`ifdef FETCH_BRANCH_STATS_EN
    , .instret_o(w_instret2), .taken_o(w_taken2)
`endif
  );

  task automatic do_reset();
    rst_n = 1'b0; r_npc = 1'b0; r_brt = '0; r_stall = 1'b0;
    r_ready = 1'b1; r_rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advances to the next negedge with inst_valid_o high (bounded).
  task automatic wait_exec(output bit ok, output int cycles);
    ok = 1'b0; cycles = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cycles++;
      if (w_inst_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({w_pc, w_inst, w_plus4, w_addr} !== {32'h0, NOP, 32'h4, 32'h0}) begin
      n_fail++; $display("FAIL reset_values: pc=%h inst=%h p4=%h addr=%h expected 0/%h/4/0", w_pc, w_inst, w_plus4, w_addr, NOP);
    end
    n_checks++;
    if ({w_inst_valid, w_req_valid, w_trap} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: valid/req/trap=%b expected 000", {w_inst_valid, w_req_valid, w_trap});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_req_valid !== 1'b1 || w_addr !== 32'h0) begin
      n_fail++; $display("FAIL boot_to_req: req=%b addr=%h expected 1/00000000", w_req_valid, w_addr);
    end
  endtask

  task automatic test_sequential();
    bit ok; int cyc;
    logic [31:0] a;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      wait_exec(ok, cyc);
      n_checks++;
      if (!ok || cyc !== (k == 0 ? 3 : 2)) begin
        n_fail++; $display("FAIL seq_latency[%0d]: ok=%b cycles=%0d expected %0d", k, ok, cyc, (k == 0 ? 3 : 2));
      end
      n_checks++;
      if (w_pc !== a || w_inst !== inst_at(a)) begin
        n_fail++; $display("FAIL seq_exec[%0d]: pc=%h inst=%h expected %h/%h", k, w_pc, w_inst, a, inst_at(a));
      end
      @(negedge clk);
      n_checks++;
      if (w_inst_valid !== 1'b0 || w_pc !== a + 32'd4 || w_inst !== NOP || w_addr !== a + 32'd4) begin
        n_fail++; $display("FAIL seq_next[%0d]: valid=%b pc=%h inst=%h addr=%h expected 0/%h/%h/%h", k, w_inst_valid, w_pc, w_inst, w_addr, a + 32'd4, NOP, a + 32'd4);
      end
    end
  endtask

  task automatic test_branch();
    bit ok; int cyc;
    wait_exec(ok, cyc);
    wait_exec(ok, cyc);
    n_checks++;
    if (!ok || w_pc !== 32'h10) begin
      n_fail++; $display("FAIL branch_at: ok=%b pc=%h expected 1/00000010", ok, w_pc);
    end
    r_npc = 1'b1; r_brt = 32'h41;
    @(negedge clk);
    r_npc = 1'b0;
    n_checks++;
    if (w_addr !== 32'h40 || w_plus4 !== 32'h44 || w_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL branch_target: addr=%h p4=%h req=%b expected 40/44/1", w_addr, w_plus4, w_req_valid);
    end
  endtask

  task automatic test_trap();
    bit ok; int cyc;
    wait_exec(ok, cyc);
    n_checks++;
    if (!ok || w_pc !== 32'h40 || w_inst !== inst_at(32'h40)) begin
      n_fail++; $display("FAIL trap_pre: ok=%b pc=%h inst=%h expected 1/40/%h", ok, w_pc, w_inst, inst_at(32'h40));
    end
    r_npc = 1'b1; r_brt = 32'h22;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      r_npc = i[0];
      n_checks++;
      if ({w_trap, w_req_valid, w_inst_valid} !== 3'b100 || w_pc !== 32'h40) begin
        n_fail++; $display("FAIL trap_sticky[%0d]: trap/req/valid=%b pc=%h expected 100/40", i, {w_trap, w_req_valid, w_inst_valid}, w_pc);
      end
    end
    r_npc = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    bit ok; int cyc;
    do_reset();
    n_checks++;
    if (w_trap !== 1'b0) begin
      n_fail++; $display("FAIL trap_cleared: trap=%b expected 0", w_trap);
    end
    r_rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({w_pc, w_inst, w_plus4} !== {32'h0, NOP, 32'h4} || {w_inst_valid, w_req_valid, w_trap} !== 3'b000) begin
      n_fail++; $display("FAIL reset_in_wait: pc=%h inst=%h p4=%h flags=%b expected 0/%h/4/000", w_pc, w_inst, w_plus4, {w_inst_valid, w_req_valid, w_trap}, NOP);
    end
    rst_n = 1'b1; r_rsp_en = 1'b1;
    wait_exec(ok, cyc);
    r_npc = 1'b1; r_brt = 32'h100; rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || w_pc !== 32'h0 || w_inst !== NOP || {w_inst_valid, w_req_valid, w_trap} !== 3'b000) begin
      n_fail++; $display("FAIL reset_in_exec: ok=%b pc=%h inst=%h flags=%b expected 1/0/%h/000", ok, w_pc, w_inst, {w_inst_valid, w_req_valid, w_trap}, NOP);
    end
`ifdef FETCH_BRANCH_STATS_EN
    n_checks++;
    if (w_instret !== 32'h0 || w_taken !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters: instret=%0d taken=%0d expected 0/0", w_instret, w_taken);
    end
`endif
    r_npc = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_stall();
    bit ok; int cyc;
    do_reset();
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (w_req_valid !== 1'b1 || w_addr !== 32'h0) begin
        n_fail++; $display("FAIL req_hold[%0d]: req=%b addr=%h expected 1/0", i, w_req_valid, w_addr);
      end
    end
    r_ready = 1'b1;
    wait_exec(ok, cyc);
    n_checks++;
    if (!ok || cyc !== 2) begin
      n_fail++; $display("FAIL stall_exec_reach: ok=%b cycles=%0d expected 1/2", ok, cyc);
    end
    r_stall = 1'b1; r_npc = 1'b1; r_brt = 32'h80;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (w_inst_valid !== 1'b1 || w_pc !== 32'h0 || w_inst !== inst_at(32'h0)) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h inst=%h expected 1/0/%h", i, w_inst_valid, w_pc, w_inst, inst_at(32'h0));
      end
    end
    r_stall = 1'b0; r_npc = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_pc !== 32'h4 || w_inst_valid !== 1'b0 || w_inst !== NOP) begin
      n_fail++; $display("FAIL stall_release: pc=%h valid=%b inst=%h expected 4/0/%h", w_pc, w_inst_valid, w_inst, NOP);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (w_valid2) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || w_pc2 !== 32'hFFFF_FFFC || w_plus4_2 !== 32'h0 || w_inst2 !== 32'h5AFF_FFFC) begin
      n_fail++; $display("FAIL wrap_exec: ok=%b pc=%h p4=%h inst=%h expected 1/FFFFFFFC/0/5AFFFFFC", ok, w_pc2, w_plus4_2, w_inst2);
    end
    @(negedge clk);
    n_checks++;
    if (w_addr2 !== 32'h0 || w_req2 !== 1'b1 || w_trap2 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_next: addr=%h req=%b trap=%b expected 0/1/0", w_addr2, w_req2, w_trap2);
    end
  endtask

`ifdef FETCH_BRANCH_STATS_EN
  task automatic test_stats();
    bit ok; int cyc;
    do_reset();
    for (int k = 0; k < 3; k++) wait_exec(ok, cyc);
    wait_exec(ok, cyc);
    r_npc = 1'b1; r_brt = 32'h41;
    @(negedge clk);
    r_npc = 1'b0;
    n_checks++;
    if (w_instret !== 32'd4 || w_taken !== 32'd1) begin
      n_fail++; $display("FAIL stats_count: instret=%0d taken=%0d expected 4/1", w_instret, w_taken);
    end
    wait_exec(ok, cyc);
    r_npc = 1'b1; r_brt = 32'h22;
    @(negedge clk);
    r_npc = 1'b0;
    n_checks++;
    if (w_trap !== 1'b1 || w_instret !== 32'd4 || w_taken !== 32'd1) begin
      n_fail++; $display("FAIL stats_trap: trap=%b instret=%0d taken=%0d expected 1/4/1", w_trap, w_instret, w_taken);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_trap();
    test_reset_midfetch();
    test_stall();
    test_wrap();
`ifdef FETCH_BRANCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
